traffic_intersection_controller: RTL and testbench

Two-lane (A/B) intersection light controller with a built-in pseudo-random traffic sensor. A 4-bit LFSR models the traffic sensors. A Moore FSM drives red/yellow/green for each lane. Lane A keeps green while it has traffic, then gives way to lane B through a timed yellow, and lane B does the same in return. Traffic inputs come either from the internal LFSR or from external pins, chosen by a select input.

---
 rtl/traffic_intersection_controller.sv | 124 ++++++++++++
 tb/tb_traffic_intersection_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_controller.sv
// Two-lane (A/B) intersection light controller.
// A 4-bit LFSR stands in for the traffic sensors. A Moore FSM drives
// red/yellow/green for both lanes, and each yellow phase is timed by an
// 8-bit counter. Lane traffic comes either from the LFSR or from the
// external pins, depending on sensor_sel.
module traffic_intersection_controller #(
   parameter int unsigned YELLOW_CYCLES = 5,       // legal range 1..255
   parameter logic [3:0]  SEED          = 4'b0001  // must be non-zero
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sensor_sel,
   input  logic       ext_ta,
   input  logic       ext_tb,
   output logic [3:0] sensor_q,
   output logic       ra,
   output logic       ya,
   output logic       ga,
   output logic       rb,
   output logic       yb,
   output logic       gb
);

   typedef enum logic [1:0] {
      S0_A_GREEN  = 2'd0,
      S1_A_YELLOW = 2'd1,
      S2_B_GREEN  = 2'd2,
      S3_B_YELLOW = 2'd3
   } state_t;

   // Value of the yellow counter in the last cycle of a yellow phase. The
   // counter starts at 0 on entry, so the phase lasts YELLOW_CYCLES cycles.
   localparam logic [7:0] YC_LAST = 8'(YELLOW_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_next;
   logic [3:0] r_lfsr;
   logic [3:0] w_lfsr_next;
   logic       w_ta;
   logic       w_tb;

   // Traffic source select. The LFSR bits are registered, so the lights
   // never depend combinationally on any input.
   assign w_ta = sensor_sel ? r_lfsr[0] : ext_ta;
   assign w_tb = sensor_sel ? r_lfsr[1] : ext_tb;

   // x^4+x^3+1 maximal-length LFSR (period 15). It never reaches 0000.
   assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

   // State, yellow counter and LFSR registers. Reset takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S0_A_GREEN;
         r_cnt   <= 8'd0;
         r_lfsr  <= SEED;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_lfsr  <= w_lfsr_next;
      end
   end

   // Next-state logic. A green phase holds while its own lane has traffic;
   // a yellow phase ignores traffic and runs until the counter expires.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S0_A_GREEN: begin
            if (!w_ta) begin
               w_state_next = S1_A_YELLOW;
               w_cnt_next   = 8'd0;
            end
         end
         S1_A_YELLOW: begin
            if (r_cnt >= YC_LAST) begin
               w_state_next = S2_B_GREEN;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         S2_B_GREEN: begin
            if (!w_tb) begin
               w_state_next = S3_B_YELLOW;
               w_cnt_next   = 8'd0;
            end
         end
         S3_B_YELLOW: begin
            if (r_cnt >= YC_LAST) begin
               w_state_next = S0_A_GREEN;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_next = S0_A_GREEN;
            w_cnt_next   = 8'd0;
         end
      endcase
   end

   // Moore light decode from the registered state only. Exactly one light
   // is on per lane, and one lane is always red.
   always_comb begin
      ra = 1'b0;
      ya = 1'b0;
      ga = 1'b0;
      rb = 1'b0;
      yb = 1'b0;
      gb = 1'b0;
      case (r_state)
         S0_A_GREEN:  begin ga = 1'b1; rb = 1'b1; end
         S1_A_YELLOW: begin ya = 1'b1; rb = 1'b1; end
         S2_B_GREEN:  begin ra = 1'b1; gb = 1'b1; end
         S3_B_YELLOW: begin ra = 1'b1; yb = 1'b1; end
         default:     begin ga = 1'b1; rb = 1'b1; end
      endcase
   end

   assign sensor_q = r_lfsr;

endmodule

// File: tb/tb_traffic_intersection_controller.sv
// Randomized self-checking bench for traffic_intersection_controller.
// The reference model tracks "which lane owns the intersection" and "how
// many yellow cycles remain", and replays the LFSR from its published
// sequence table.
module tb_traffic_intersection_controller;

   localparam int YC = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sensor_sel = 1'b0;
   logic       ext_ta = 1'b1;
   logic       ext_tb = 1'b1;
   logic [3:0] sensor_q;
   logic       ra, ya, ga, rb, yb, gb;

   int n_checks = 0;
   int n_errors = 0;
   int n_steps  = 0;

   // Reference model state.
   logic [3:0] m_seq [15];
   int         m_idx;        // position in the LFSR sequence
   int         m_lane;       // 0 = lane A owns the intersection, 1 = lane B
   int         m_yleft;      // yellow cycles remaining, 0 = green

   always #5 clk = ~clk;

   traffic_intersection_controller #(
      .YELLOW_CYCLES(YC),
      .SEED         (4'b0001)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sensor_sel(sensor_sel),
      .ext_ta    (ext_ta),
      .ext_tb    (ext_tb),
      .sensor_q  (sensor_q),
      .ra        (ra),
      .ya        (ya),
      .ga        (ga),
      .rb        (rb),
      .yb        (yb),
      .gb        (gb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (step %0d)", tag, got, exp, n_steps);
      end
   endtask

   // Advance the model by one rising edge using the inputs the DUT saw.
   task automatic model_edge(input logic rst, input logic sel, input logic ta_x, input logic tb_x);
      logic ta, tb, t_own;
      ta = sel ? m_seq[m_idx][0] : ta_x;
      tb = sel ? m_seq[m_idx][1] : tb_x;
      if (rst) begin
         m_idx = 0; m_lane = 0; m_yleft = 0;
      end else begin
         if (m_yleft > 0) begin
            m_yleft--;
            if (m_yleft == 0) m_lane = 1 - m_lane;
         end else begin
            t_own = (m_lane == 0) ? ta : tb;
            if (!t_own) m_yleft = YC;
         end
         m_idx = (m_idx + 1) % 15;
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare all outputs.
   task automatic step(input logic rst, input logic sel, input logic ta_x, input logic tb_x);
      logic [5:0] exp_l;
      reset = rst; sensor_sel = sel; ext_ta = ta_x; ext_tb = tb_x;
      @(posedge clk);
      model_edge(rst, sel, ta_x, tb_x);
      #1;
      n_steps++;
      exp_l[5] = (m_lane == 1);                  // ra
      exp_l[4] = (m_lane == 0) && (m_yleft > 0); // ya
      exp_l[3] = (m_lane == 0) && (m_yleft == 0);// ga
      exp_l[2] = (m_lane == 0);                  // rb
      exp_l[1] = (m_lane == 1) && (m_yleft > 0); // yb
      exp_l[0] = (m_lane == 1) && (m_yleft == 0);// gb
      $display("step %0d rst=%0b sel=%0b ta=%0b tb=%0b q=%b lights(ra ya ga rb yb gb)=%b",
               n_steps, rst, sel, ta_x, tb_x, sensor_q, {ra, ya, ga, rb, yb, gb});
      chk("sensor_q", 32'(sensor_q), 32'(m_seq[m_idx]));
      chk("lights", 32'({ra, ya, ga, rb, yb, gb}), 32'(exp_l));
      chk("onehot_a", 32'($onehot({ra, ya, ga})), 32'd1);
      chk("onehot_b", 32'($onehot({rb, yb, gb})), 32'd1);
      chk("one_red", 32'(ra | rb), 32'd1);
   endtask

   initial begin
      logic [3:0] tbl [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      for (int i = 0; i < 15; i++) m_seq[i] = tbl[i];
      m_idx = 0; m_lane = 0; m_yleft = 0;

      // Reset for two cycles, then lane A green with sensor at the seed.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("reset_lights", 32'({ra, ya, ga, rb, yb, gb}), 32'b001100);
      chk("reset_seed", 32'(sensor_q), 32'b0001);

      // Lane A keeps green while it has traffic; lane B input is irrelevant.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom));
      chk("a_green_held", 32'(ga & rb), 32'd1);

      // Drop ta: yellow for YC cycles regardless of ta toggling, then B green.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("a_yellow_now", 32'(ya & rb), 32'd1);
      for (int i = 0; i < YC - 1; i++) step(1'b0, 1'b0, 1'($urandom), 1'b1);
      chk("a_yellow_last", 32'(ya), 32'd1);
      step(1'b0, 1'b0, 1'($urandom), 1'b1);
      chk("b_green", 32'(ra & gb), 32'd1);

      // B holds green with traffic, then yields through its own yellow.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'($urandom), 1'b1);
      chk("b_green_held", 32'(gb), 32'd1);
      for (int i = 0; i < YC + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("back_to_a", 32'(ga & rb), 32'd1);

      // LFSR-driven sensors: full period and lights following q[0]/q[1].
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 1'($urandom), 1'($urandom));

      // Reset in the 3rd cycle of A yellow, then a fresh full-length yellow.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);           // 1st yellow cycle begins
      step(1'b0, 1'b0, 1'b1, 1'b1);           // 2nd
      step(1'b0, 1'b0, 1'b1, 1'b1);           // 3rd
      step(1'b1, 1'b0, 1'b1, 1'b1);           // reset sampled here
      chk("midyellow_reset", 32'({ra, ya, ga, rb, yb, gb, sensor_q}), 32'({6'b001100, 4'b0001}));
      step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < YC + 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized mix, including occasional reset.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
